// File: rtl/regfile_param.sv
// Register file: one write port, two combinational read ports, optional bypass, zero reg and bulk clear.
// Latency: reads are combinational, writes commit on the next edge, and a clear sweep takes DEPTH cycles plus one DONE cycle.
// Backpressure: writes are dropped while clr_busy/clr_done are high. Parity is optional via REGFILE_PARITY_EN.
module regfile_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WR,
    input  logic [DATA_W-1:0] DW,
    input  logic [ADDR_W-1:0] RR1,
    input  logic [ADDR_W-1:0] RR2,
    output logic [DATA_W-1:0] DR1,
    output logic [DATA_W-1:0] DR2,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
`ifdef REGFILE_PARITY_EN
    ,
    input  logic              par_inj,
    output logic              perr1,
    output logic              perr2
`endif
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SWEEP = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [DATA_W-1:0] mem [DEPTH];
`ifdef REGFILE_PARITY_EN
    logic              par_mem [DEPTH];
`endif
    logic [1:0]        state;
    logic [ADDR_W-1:0] cnt;
    logic              wr_ok;
    logic              byp1, byp2;
    logic              z1, z2;

    // Writes to the hardwired zero register never commit, so they never bypass either.
    assign wr_ok = RegWrite && (state == S_IDLE) && !((ZERO_REG != 0) && (WR == '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
`ifdef REGFILE_PARITY_EN
                par_mem[i] <= 1'b0;
`endif
            end
            state    <= S_IDLE;
            cnt      <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (wr_ok) begin
                        mem[WR] <= DW;
`ifdef REGFILE_PARITY_EN
                        par_mem[WR] <= (^DW) ^ par_inj;
`endif
                    end
                    if (clr_req) begin
                        state    <= S_SWEEP;
                        cnt      <= '0;
                        clr_busy <= 1'b1;
                    end
                end
                S_SWEEP: begin
                    mem[cnt] <= '0;
`ifdef REGFILE_PARITY_EN
                    par_mem[cnt] <= 1'b0;
`endif
                    cnt <= cnt + ADDR_W'(1);
                    if (cnt == LAST) begin
                        state    <= S_DONE;
                        clr_busy <= 1'b0;
                        clr_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    clr_done <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    clr_busy <= 1'b0;
                    clr_done <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        z1   = (ZERO_REG != 0) && (RR1 == '0);
        z2   = (ZERO_REG != 0) && (RR2 == '0);
        byp1 = (BYPASS != 0) && wr_ok && (WR == RR1);
        byp2 = (BYPASS != 0) && wr_ok && (WR == RR2);
        DR1  = z1 ? '0 : (byp1 ? DW : mem[RR1]);
        DR2  = z2 ? '0 : (byp2 ? DW : mem[RR2]);
    end

`ifdef REGFILE_PARITY_EN
    // Even parity: data XOR stored bit is zero for an intact register.
    assign perr1 = !(z1 || byp1) && ((^mem[RR1]) != par_mem[RR1]);
    assign perr2 = !(z2 || byp2) && ((^mem[RR2]) != par_mem[RR2]);
`endif

endmodule
